jt89_wrq: RTL and testbench

Write queue and pacing stage that sits directly upstream of the jt89 PSG core. It captures CPU byte writes into a small FIFO and replays them to the PSG register port as single-cycle write strobes, spaced by a programmable number of PSG clock enables. It also drives a READY-style handshake back to the CPU so that fast bus masters can write back-to-back without losing bytes.

---
 rtl/jt89_wrq.sv | 159 +++++++++++++++
 tb/tb_jt89_wrq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt89_wrq.sv
// rtl/jt89_wrq.sv - CPU write queue and paced write-strobe generator for the jt89 PSG
module jt89_wrq #(
    parameter int AW   = 2,
    parameter int HOLD = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clken,
    input  logic          cs_n,
    input  logic          cpu_wr_n,
    input  logic [7:0]    cpu_din,
    output logic          ready,
    output logic          psg_wr_n,
    output logic [7:0]    psg_din,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          overflow
);

    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL     = {1'b1, {AW{1'b0}}};
    localparam logic [7:0]  HOLD_CNT = 8'(HOLD);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [7:0]      cnt;
    logic [7:0]      cnt_nx;

    logic            wr_prev;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;

    logic            push_det;
    logic            pop;
    logic            push_ok;

    // A held CPU strobe is reduced to one push by looking for its falling edge.
    assign push_det = ~cs_n & ~cpu_wr_n & wr_prev;

    // The head is only taken when the PSG port is idle; a same-cycle pop frees
    // the slot a push into a full queue needs.
    assign pop     = (state == S_IDLE) && (level != '0);
    assign push_ok = push_det && ((level != FULL) || pop);

    assign ready = (level != FULL);
    assign empty = (level == '0);

    // Previous CPU strobe level for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_prev <= 1'b1;
        end else begin
            wr_prev <= cpu_wr_n;
        end
    end

    // Queue storage; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= cpu_din;
        end
    end

    // Pointers and occupancy; push and pop together leave level unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            if (push_ok && !pop) begin
                level <= level + (AW+1)'(1);
            end else if (pop && !push_ok) begin
                level <= level - (AW+1)'(1);
            end
        end
    end

    // Sticky record that a CPU byte was lost to a full queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (push_det && !push_ok) begin
            overflow <= 1'b1;
        end
    end

    // Issued byte is latched at pop time and held until the next issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            psg_din <= 8'h00;
        end else if (pop) begin
            psg_din <= mem[rptr];
        end
    end

    // Registered strobe: low exactly for the cycle the drain FSM sits in ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            psg_wr_n <= 1'b1;
        end else begin
            psg_wr_n <= (state_nx != S_ISSUE);
        end
    end

    // Drain FSM state and hold counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Drain FSM next state: issue one byte, then hold off for HOLD clken pulses.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_IDLE: begin
                if (pop) begin
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_nx   = HOLD_CNT;
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (clken) begin
                    cnt_nx = cnt - 8'd1;
                    if (cnt_nx == 8'd0) begin
                        state_nx = S_IDLE;
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = 8'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_jt89_wrq.sv
// tb/tb_jt89_wrq.sv - self-checking bench for jt89_wrq against a queue-based reference model
module tb_jt89_wrq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs_n = 1'b1;
    logic        cpu_wr_n = 1'b1;
    logic [7:0]  cpu_din = 8'h00;
    logic        clken_i [2];

    logic        ready_o  [2];
    logic        wr_n_o   [2];
    logic [7:0]  din_o    [2];
    logic        empty_o  [2];
    logic [2:0]  level_o  [2];
    logic        ovf_o    [2];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int cm [2];
    int hold_p [2];

    logic [7:0]  mq [2][$];
    logic        mprev [2];
    logic        movf  [2];
    int          mph   [2];
    int          mrem  [2];
    logic [7:0]  mdin  [2];

    int          st_cyc [2][$];
    logic [7:0]  st_dat [2][$];
    logic        hist1 [0:19999];

    always #5 clk = ~clk;

    jt89_wrq #(.AW(2), .HOLD(32)) u0 (
        .clk(clk), .rst(rst), .clken(clken_i[0]), .cs_n(cs_n), .cpu_wr_n(cpu_wr_n),
        .cpu_din(cpu_din), .ready(ready_o[0]), .psg_wr_n(wr_n_o[0]), .psg_din(din_o[0]),
        .empty(empty_o[0]), .level(level_o[0]), .overflow(ovf_o[0])
    );

    jt89_wrq #(.AW(2), .HOLD(2)) u1 (
        .clk(clk), .rst(rst), .clken(clken_i[1]), .cs_n(cs_n), .cpu_wr_n(cpu_wr_n),
        .cpu_din(cpu_din), .ready(ready_o[1]), .psg_wr_n(wr_n_o[1]), .psg_din(din_o[1]),
        .empty(empty_o[1]), .level(level_o[1]), .overflow(ovf_o[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: the port is free, strobing, or busy for a number of clken pulses.
    task automatic model_step(input int d);
        logic       do_pop;
        logic       do_push;
        int         sz;
        logic [7:0] head;
        head = 8'h00;
        if (rst) begin
            mq[d].delete();
            mprev[d] = 1'b1;
            movf[d]  = 1'b0;
            mph[d]   = 0;
            mrem[d]  = 0;
            mdin[d]  = 8'h00;
        end else begin
            sz      = mq[d].size();
            do_pop  = (mph[d] == 0) && (sz > 0);
            do_push = !cs_n && !cpu_wr_n && mprev[d];
            if (do_pop) head = mq[d].pop_front();
            if (do_push) begin
                if (sz < 4 || do_pop) mq[d].push_back(cpu_din);
                else movf[d] = 1'b1;
            end
            if (mph[d] == 0) begin
                if (do_pop) begin
                    mph[d]  = 1;
                    mdin[d] = head;
                end
            end else if (mph[d] == 1) begin
                mph[d]  = 2;
                mrem[d] = hold_p[d];
            end else if (clken_i[d]) begin
                mrem[d]--;
                if (mrem[d] == 0) mph[d] = 0;
            end
            mprev[d] = cpu_wr_n;
        end
    endtask

    task automatic tick();
        for (int d = 0; d < 2; d++) begin
            case (cm[d])
                0:       clken_i[d] = 1'b1;
                1:       clken_i[d] = 1'b0;
                2:       clken_i[d] = (cyc % 16 == 0);
                default: clken_i[d] = ($urandom_range(0, 3) == 0);
            endcase
        end
        if (cyc < 20000) hist1[cyc] = clken_i[1];
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            model_step(d);
            chk($sformatf("u%0d_level", d), 32'(level_o[d]), 32'(mq[d].size()));
            chk($sformatf("u%0d_empty", d), 32'(empty_o[d]), 32'(mq[d].size() == 0));
            chk($sformatf("u%0d_ready", d), 32'(ready_o[d]), 32'(mq[d].size() < 4));
            chk($sformatf("u%0d_wr_n", d), 32'(wr_n_o[d]), 32'(mph[d] != 1));
            chk($sformatf("u%0d_din", d), 32'(din_o[d]), 32'(mdin[d]));
            chk($sformatf("u%0d_ovf", d), 32'(ovf_o[d]), 32'(movf[d]));
            if (wr_n_o[d] === 1'b0) begin
                st_cyc[d].push_back(cyc);
                st_dat[d].push_back(din_o[d]);
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic write_byte(input logic [7:0] b, input int low_cycles);
        cs_n     = 1'b0;
        cpu_din  = b;
        cpu_wr_n = 1'b0;
        run(low_cycles);
        cpu_wr_n = 1'b1;
        cs_n     = 1'b1;
        tick();
    endtask

    task automatic clear_logs();
        for (int d = 0; d < 2; d++) begin
            st_cyc[d].delete();
            st_dat[d].delete();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int c0;
        int s1;
        int s2;
        int pulses;
        logic [7:0] burst [4];
        burst     = '{8'h80, 8'h05, 8'hA0, 8'h1A};
        hold_p    = '{32, 2};
        cm        = '{0, 0};
        clken_i   = '{1'b1, 1'b1};
        mprev     = '{1'b1, 1'b1};
        movf      = '{1'b0, 1'b0};
        mph       = '{0, 0};
        mrem      = '{0, 0};
        mdin      = '{8'h00, 8'h00};

        // Reset state
        rst = 1'b1;
        run(3);
        chk("rst_ready", 32'(ready_o[0]), 32'd1);
        chk("rst_wr_n", 32'(wr_n_o[0]), 32'd1);
        chk("rst_din", 32'(din_o[0]), 32'h00);
        chk("rst_empty", 32'(empty_o[0]), 32'd1);
        chk("rst_level", 32'(level_o[0]), 32'd0);
        chk("rst_ovf", 32'(ovf_o[0]), 32'd0);
        rst = 1'b0;
        tick();

        // Single held write
        clear_logs();
        c0 = cyc;
        write_byte(8'h9F, 5);
        run(45);
        chk("single_count", 32'(st_cyc[0].size()), 32'd1);
        if (st_cyc[0].size() == 1) begin
            chk("single_data", 32'(st_dat[0][0]), 32'h9F);
            chk("single_latency", 32'(st_cyc[0][0]), 32'(c0 + 2));
        end
        chk("single_level", 32'(level_o[0]), 32'd0);
        chk("single_ovf", 32'(ovf_o[0]), 32'd0);

        // Burst of four writes two cycles apart
        clear_logs();
        for (int i = 0; i < 4; i++) write_byte(burst[i], 1);
        run(4 * 34 + 10);
        chk("burst_count", 32'(st_cyc[0].size()), 32'd4);
        if (st_cyc[0].size() == 4) begin
            for (int i = 0; i < 4; i++)
                chk($sformatf("burst_data%0d", i), 32'(st_dat[0][i]), 32'(burst[i]));
            for (int i = 1; i < 4; i++)
                chk($sformatf("burst_gap%0d", i), 32'(st_cyc[0][i] - st_cyc[0][i-1]), 32'd34);
        end

        // Overflow with the drain stalled
        do_reset();
        cm = '{1, 1};
        clear_logs();
        for (int i = 0; i < 6; i++) write_byte(8'(8'h10 + i), 1);
        chk("ovf_level", 32'(level_o[0]), 32'd4);
        chk("ovf_flag", 32'(ovf_o[0]), 32'd1);
        chk("ovf_ready", 32'(ready_o[0]), 32'd0);
        chk("ovf_issued", 32'(st_cyc[0].size()), 32'd1);
        cm = '{0, 0};
        run(200);
        chk("ovf_sticky", 32'(ovf_o[0]), 32'd1);
        chk("ovf_drained", 32'(st_cyc[0].size()), 32'd5);
        if (st_cyc[0].size() == 5) chk("ovf_last", 32'(st_dat[0][4]), 32'h14);
        do_reset();
        tick();
        chk("ovf_cleared", 32'(ovf_o[0]), 32'd0);

        // Stall: HOLD=2 instance sees one clken per 16 clk
        cm = '{0, 2};
        clear_logs();
        write_byte(8'h3C, 1);
        write_byte(8'hC3, 1);
        run(120);
        chk("stall_count", 32'(st_cyc[1].size()), 32'd2);
        if (st_cyc[1].size() == 2) begin
            s1 = st_cyc[1][0];
            s2 = st_cyc[1][1];
            pulses = 0;
            for (int c = s1 + 1; c <= s2 - 2; c++) if (hist1[c]) pulses++;
            chk("stall_pulses", 32'(pulses), 32'd2);
            chk("stall_last_pulse", 32'(hist1[s2-2]), 32'd1);
            chk("stall_data", 32'(st_dat[1][1]), 32'hC3);
        end

        // Reset during WAIT with three bytes queued
        cm = '{0, 0};
        do_reset();
        for (int i = 0; i < 4; i++) write_byte(8'(8'h40 + i), 1);
        chk("rmid_level3", 32'(level_o[0]), 32'd3);
        chk("rmid_waiting", 32'(wr_n_o[0]), 32'd1);
        do_reset();
        chk("rmid_level0", 32'(level_o[0]), 32'd0);
        chk("rmid_empty", 32'(empty_o[0]), 32'd1);
        chk("rmid_wr_n", 32'(wr_n_o[0]), 32'd1);
        clear_logs();
        run(80);
        chk("rmid_no_strobe", 32'(st_cyc[0].size()), 32'd0);

        // Chip select gating
        cs_n = 1'b1;
        cpu_din = 8'h77;
        cpu_wr_n = 1'b0;
        run(2);
        cpu_wr_n = 1'b1;
        tick();
        chk("csn_level", 32'(level_o[0]), 32'd0);
        chk("csn_no_strobe", 32'(st_cyc[0].size()), 32'd0);

        // Randomized traffic with random clken and occasional reset
        cm = '{3, 3};
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 599) == 0);
            cs_n     = ($urandom_range(0, 7) == 0);
            cpu_wr_n = ($urandom_range(0, 2) != 0);
            cpu_din  = 8'($urandom);
            tick();
        end
        rst = 1'b0;
        cs_n = 1'b1;
        cpu_wr_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
